// File: rtl/btb_update_ctrl_pkg.sv
// btb_pkg: shared types and constants for the BTB update controller.
//   PC_W      program-counter width
//   PC_INC    default next-sequential PC increment
//   res_e     outcome of resolving the EX-stage prediction
//   wr_rec_t  captured BTB write record {pc, tgt, state}
//   classify  maps (branch valid, predicted, taken, target match) to res_e
package btb_pkg;

  localparam int unsigned PC_W = 32;
  localparam logic [PC_W-1:0] PC_INC = 32'd4;

  typedef enum logic [2:0] {
    RES_OK,     // prediction correct, nothing to do
    RES_TGT,    // predicted taken, taken, wrong target
    RES_NT,     // predicted taken, not taken
    RES_T,      // not predicted, taken
    RES_ALIAS   // BTB hit on a non-branch
  } res_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] tgt;
    logic            state;
  } wr_rec_t;

  function automatic res_e classify(input logic b, input logic p,
                                    input logic t, input logic tgt_match);
    res_e r;
    r = RES_OK;
    if (b) begin
      if (p) begin
        if (!t)             r = RES_NT;
        else if (!tgt_match) r = RES_TGT;
      end else if (t) begin
        r = RES_T;
      end
    end else if (p) begin
      r = RES_ALIAS;
    end
    return r;
  endfunction

endpackage

// File: rtl/btb_update_ctrl_if.sv
// btb_update_ctrl_if: groups the BTB read result, hazard controls, EX-stage
// branch outcome and the controller outputs (redirect + BTB write port).
//   slave  : the controller (btb_update_ctrl)
//   master : the surrounding core / testbench
// Optional macro BTB_PERF_EN adds br_cnt / mispred_cnt.
interface btb_update_ctrl_if;
  import btb_pkg::*;

  logic            rd_predicted;
  logic [PC_W-1:0] rd_predicted_PC;
  logic            bubbleD;
  logic            flushD;
  logic            bubbleE;
  logic            flushE;
  logic [PC_W-1:0] PCE;
  logic            br_valid_E;
  logic            br_taken_E;
  logic [PC_W-1:0] br_target_E;
  logic            mispredict;
  logic [PC_W-1:0] redirect_PC;
  logic            wr_req;
  logic [PC_W-1:0] wr_PC;
  logic [PC_W-1:0] wr_predicted_PC;
  logic            wr_predicted_state_bit;
`ifdef BTB_PERF_EN
  logic [31:0]     br_cnt;
  logic [31:0]     mispred_cnt;
`endif

  modport slave (
    input  rd_predicted, rd_predicted_PC, bubbleD, flushD, bubbleE, flushE,
           PCE, br_valid_E, br_taken_E, br_target_E,
    output mispredict, redirect_PC, wr_req, wr_PC, wr_predicted_PC,
           wr_predicted_state_bit
`ifdef BTB_PERF_EN
           , br_cnt, mispred_cnt
`endif
  );

  modport master (
    output rd_predicted, rd_predicted_PC, bubbleD, flushD, bubbleE, flushE,
           PCE, br_valid_E, br_taken_E, br_target_E,
    input  mispredict, redirect_PC, wr_req, wr_PC, wr_predicted_PC,
           wr_predicted_state_bit
`ifdef BTB_PERF_EN
           , br_cnt, mispred_cnt
`endif
  );

endinterface

// File: rtl/btb_pred_stage_reg.sv
// btb_pred_stage_reg: one pipeline register for the fetch-time prediction
// {pred, pred_pc}. flush clears (highest priority), bubble holds, else load.
//   clk, rst        clock, async active-high reset
//   flush, bubble   clear / hold controls
//   pred_in, pc_in  incoming prediction
//   pred_out,pc_out registered prediction
module btb_pred_stage_reg
  import btb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            bubble,
  input  logic            pred_in,
  input  logic [PC_W-1:0] pc_in,
  output logic            pred_out,
  output logic [PC_W-1:0] pc_out
);

  logic            pred_q, pred_d;
  logic [PC_W-1:0] pc_q, pc_d;

  always_comb begin
    pred_d = pred_q;
    pc_d   = pc_q;
    if (flush) begin
      pred_d = 1'b0;
      pc_d   = '0;
    end else if (!bubble) begin
      pred_d = pred_in;
      pc_d   = pc_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_q <= 1'b0;
      pc_q   <= '0;
    end else begin
      pred_q <= pred_d;
      pc_q   <= pc_d;
    end
  end

  assign pred_out = pred_q;
  assign pc_out   = pc_q;

endmodule

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: carries each BTB prediction IF->D->E, resolves it in EX
// against the real branch outcome, redirects fetch on a mispredict and
// issues a one-cycle BTB write one cycle later.
//   clk, rst  core clock, async active-high reset
//   bus       btb_update_ctrl_if.slave (BTB read, hazards, EX outcome,
//             mispredict/redirect_PC, wr_* write port)
//   PC_INC    next-sequential increment for not-taken redirects
// Optional macro BTB_PERF_EN: saturating br_cnt / mispred_cnt on the bus.
module btb_update_ctrl #(
  parameter logic [31:0] PC_INC = btb_pkg::PC_INC
) (
  input logic             clk,
  input logic             rst,
  btb_update_ctrl_if.slave bus
);
  import btb_pkg::*;

  logic            pred_D, pred_E;
  logic [PC_W-1:0] pc_D, pc_E;

  btb_pred_stage_reg u_stage_d (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.flushD),
    .bubble   (bus.bubbleD),
    .pred_in  (bus.rd_predicted),
    .pc_in    (bus.rd_predicted_PC),
    .pred_out (pred_D),
    .pc_out   (pc_D)
  );

  btb_pred_stage_reg u_stage_e (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.flushE),
    .bubble   (bus.bubbleE),
    .pred_in  (pred_D),
    .pc_in    (pc_D),
    .pred_out (pred_E),
    .pc_out   (pc_E)
  );

  res_e            res;
  logic            mis;
  logic [PC_W-1:0] redirect;
  wr_rec_t         rec;

  logic    done_q, done_d;
  logic    wr_req_q, wr_req_d;
  wr_rec_t wr_rec_q, wr_rec_d;

  // Resolution is suppressed once the current EX occupant has already
  // resolved during a stall, so a held branch pulses only once.
  always_comb begin
    res      = RES_OK;
    redirect = '0;
    rec      = '0;
    if (!done_q)
      res = classify(bus.br_valid_E, pred_E, bus.br_taken_E,
                     bus.br_target_E == pc_E);
    case (res)
      RES_TGT, RES_T: begin
        redirect = bus.br_target_E;
        rec      = '{pc: bus.PCE, tgt: bus.br_target_E, state: 1'b1};
      end
      RES_NT, RES_ALIAS: begin
        redirect = bus.PCE + PC_INC;
        rec      = '{pc: bus.PCE, tgt: pc_E, state: 1'b0};
      end
      default: ;
    endcase
    mis = (res != RES_OK);
  end

  always_comb begin
    done_d   = done_q;
    wr_req_d = mis;
    wr_rec_d = mis ? rec : wr_rec_q;
    if (bus.flushE || !bus.bubbleE)
      done_d = 1'b0;
    else if (!done_q && (bus.br_valid_E || pred_E))
      done_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q   <= 1'b0;
      wr_req_q <= 1'b0;
      wr_rec_q <= '0;
    end else begin
      done_q   <= done_d;
      wr_req_q <= wr_req_d;
      wr_rec_q <= wr_rec_d;
    end
  end

  assign bus.mispredict             = mis;
  assign bus.redirect_PC            = redirect;
  assign bus.wr_req                 = wr_req_q;
  assign bus.wr_PC                  = wr_rec_q.pc;
  assign bus.wr_predicted_PC        = wr_rec_q.tgt;
  assign bus.wr_predicted_state_bit = wr_rec_q.state;

`ifdef BTB_PERF_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    br_cnt_d      = br_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (!done_q && bus.br_valid_E && br_cnt_q != '1)
      br_cnt_d = br_cnt_q + 32'd1;
    if (mis && mispred_cnt_q != '1)
      mispred_cnt_d = mispred_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      br_cnt_q      <= br_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bus.br_cnt      = br_cnt_q;
  assign bus.mispred_cnt = mispred_cnt_q;
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_btb_update_ctrl.sv
module tb_btb_update_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  btb_update_ctrl_if bus ();

  btb_update_ctrl #(.PC_INC(32'd4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rd_predicted    = 1'b0;
    bus.rd_predicted_PC = '0;
    bus.bubbleD = 1'b0; bus.flushD = 1'b0;
    bus.bubbleE = 1'b0; bus.flushE = 1'b0;
    bus.PCE = '0; bus.br_valid_E = 1'b0; bus.br_taken_E = 1'b0;
    bus.br_target_E = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Place a prediction into EX: fetch cycle, then one more cycle through D.
  task automatic push_pred(input logic p, input logic [31:0] ppc);
    bus.rd_predicted = p; bus.rd_predicted_PC = ppc;
    tick();
    bus.rd_predicted = 1'b0; bus.rd_predicted_PC = '0;
    tick();
  endtask

  task automatic set_ex(input logic [31:0] pce, input logic b, input logic t,
                        input logic [31:0] tgt);
    bus.PCE = pce; bus.br_valid_E = b; bus.br_taken_E = t; bus.br_target_E = tgt;
  endtask

  typedef struct {
    logic        p;
    logic [31:0] ppc;
    logic [31:0] pce;
    logic        b;
    logic        t;
    logic [31:0] tgt;
    logic        mis;
    logic [31:0] red;
    logic        wreq;
    logic [31:0] wpc;
    logic [31:0] wtgt;
    logic        wst;
  } vec_t;

  vec_t vt[9];

  // Reference model state
  logic        m_dp, m_ep, m_done, m_wreq, m_wst;
  logic [31:0] m_dpc, m_epc, m_wpc, m_wtgt;
  logic [31:0] m_br, m_mis;

  initial begin
    int mis_pulses, wr_pulses;

    vt[0] = '{1'b1, 32'h100, 32'h0F0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0};
    vt[1] = '{1'b0, 32'h000, 32'h040, 1'b1, 1'b1, 32'h080, 1'b1, 32'h080, 1'b1, 32'h040, 32'h080, 1'b1};
    vt[2] = '{1'b1, 32'h200, 32'h01C, 1'b1, 1'b0, 32'h999, 1'b1, 32'h020, 1'b1, 32'h01C, 32'h200, 1'b0};
    vt[3] = '{1'b1, 32'h500, 32'h030, 1'b0, 1'b0, 32'h0, 1'b1, 32'h034, 1'b1, 32'h030, 32'h500, 1'b0};
    vt[4] = '{1'b1, 32'h300, 32'h010, 1'b1, 1'b1, 32'h400, 1'b1, 32'h400, 1'b1, 32'h010, 32'h400, 1'b1};
    vt[5] = '{1'b1, 32'h700, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h8, 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h700, 1'b0};
    vt[6] = '{1'b0, 32'h000, 32'h060, 1'b1, 1'b0, 32'h90, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0};
    vt[7] = '{1'b0, 32'h000, 32'h064, 1'b0, 1'b1, 32'h90, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0};
    vt[8] = '{1'b0, 32'h000, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h0, 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h0, 1'b1};

    // Reset state
    idle_inputs();
    #2;
    chk("rst_mispredict", {31'b0, bus.mispredict}, 32'h0);
    chk("rst_wr_req", {31'b0, bus.wr_req}, 32'h0);
    tick();
    rst = 1'b0;
    chk("rst_redirect", bus.redirect_PC, 32'h0);
    chk("rst_wr_PC", bus.wr_PC, 32'h0);
    chk("rst_wr_tgt", bus.wr_predicted_PC, 32'h0);
    chk("rst_wr_state", {31'b0, bus.wr_predicted_state_bit}, 32'h0);
`ifdef BTB_PERF_EN
    chk("rst_br_cnt", bus.br_cnt, 32'h0);
    chk("rst_mispred_cnt", bus.mispred_cnt, 32'h0);
`endif

    // Table-driven single resolutions
    for (int i = 0; i < 9; i++) begin
      push_pred(vt[i].p, vt[i].ppc);
      set_ex(vt[i].pce, vt[i].b, vt[i].t, vt[i].tgt);
      #2;
      chk($sformatf("vec%0d_mispredict", i), {31'b0, bus.mispredict}, {31'b0, vt[i].mis});
      if (vt[i].mis)
        chk($sformatf("vec%0d_redirect", i), bus.redirect_PC, vt[i].red);
      tick();
      set_ex('0, 1'b0, 1'b0, '0);
      chk($sformatf("vec%0d_wr_req", i), {31'b0, bus.wr_req}, {31'b0, vt[i].wreq});
      if (vt[i].wreq) begin
        chk($sformatf("vec%0d_wr_PC", i), bus.wr_PC, vt[i].wpc);
        chk($sformatf("vec%0d_wr_tgt", i), bus.wr_predicted_PC, vt[i].wtgt);
        chk($sformatf("vec%0d_wr_state", i), {31'b0, bus.wr_predicted_state_bit}, {31'b0, vt[i].wst});
      end
    end

    // Hit correct: no write over the following 3 cycles
    push_pred(1'b1, 32'h100);
    set_ex(32'h0F0, 1'b1, 1'b1, 32'h100);
    wr_pulses = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      set_ex('0, 1'b0, 1'b0, '0);
      if (bus.wr_req) wr_pulses++;
    end
    chk("hit_no_wr", wr_pulses, 0);

    // Stall: cold taken held in EX for 3 cycles, then advancing
    push_pred(1'b0, 32'h0);
    set_ex(32'h40, 1'b1, 1'b1, 32'h80);
    bus.bubbleD = 1'b1; bus.bubbleE = 1'b1;
    mis_pulses = 0; wr_pulses = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin bus.bubbleD = 1'b0; bus.bubbleE = 1'b0; end
      #2;
      if (bus.mispredict) mis_pulses++;
      tick();
      if (bus.wr_req) wr_pulses++;
      if (k == 0) begin
        chk("stall_wr_PC", bus.wr_PC, 32'h40);
        chk("stall_wr_tgt", bus.wr_predicted_PC, 32'h80);
      end
    end
    set_ex('0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 2; k++) begin
      #2;
      if (bus.mispredict) mis_pulses++;
      tick();
      if (bus.wr_req) wr_pulses++;
    end
    chk("stall_mis_pulses", mis_pulses, 1);
    chk("stall_wr_pulses", wr_pulses, 1);

    // Prediction flushed from D (with E) never reaches EX
    bus.rd_predicted = 1'b1; bus.rd_predicted_PC = 32'h500;
    tick();
    bus.rd_predicted = 1'b0; bus.rd_predicted_PC = '0;
    bus.flushD = 1'b1; bus.flushE = 1'b1;
    tick();
    bus.flushD = 1'b0; bus.flushE = 1'b0;
    set_ex(32'h30, 1'b0, 1'b0, '0);
    mis_pulses = 0; wr_pulses = 0;
    for (int k = 0; k < 3; k++) begin
      #2;
      if (bus.mispredict) mis_pulses++;
      tick();
      if (bus.wr_req) wr_pulses++;
    end
    chk("flushD_no_mis", mis_pulses, 0);
    chk("flushD_no_wr", wr_pulses, 0);
    set_ex('0, 1'b0, 1'b0, '0);

    // flushE in the resolving cycle: resolution still fires
    push_pred(1'b0, 32'h0);
    set_ex(32'h44, 1'b1, 1'b1, 32'hC0);
    bus.flushE = 1'b1;
    #2;
    chk("flushE_mispredict", {31'b0, bus.mispredict}, 32'h1);
    chk("flushE_redirect", bus.redirect_PC, 32'hC0);
    tick();
    bus.flushE = 1'b0;
    set_ex(32'h48, 1'b0, 1'b0, '0);
    chk("flushE_wr_req", {31'b0, bus.wr_req}, 32'h1);
    chk("flushE_wr_PC", bus.wr_PC, 32'h44);
    #2;
    chk("flushE_cleared", {31'b0, bus.mispredict}, 32'h0);
    tick();
    set_ex('0, 1'b0, 1'b0, '0);

    // Reset mid-operation aborts a pending write
    push_pred(1'b1, 32'h600);
    set_ex(32'h50, 1'b0, 1'b0, '0);
    #2;
    chk("rstmid_mis_before", {31'b0, bus.mispredict}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rstmid_mis_async", {31'b0, bus.mispredict}, 32'h0);
    tick();
    chk("rstmid_no_wr", {31'b0, bus.wr_req}, 32'h0);
    chk("rstmid_wr_PC", bus.wr_PC, 32'h0);
    rst = 1'b0;
    push_pred(1'b0, 32'h0);
    set_ex(32'h54, 1'b1, 1'b1, 32'h70);
    tick();
    set_ex('0, 1'b0, 1'b0, '0);
    chk("rstmid2_wr_req", {31'b0, bus.wr_req}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid2_wr_req_async", {31'b0, bus.wr_req}, 32'h0);
    tick();
    rst = 1'b0;

`ifdef BTB_PERF_EN
    // 10 branches, 3 mispredicts
    do_reset();
    for (int i = 0; i < 10; i++) begin
      logic bad;
      bad = (i == 2 || i == 5 || i == 8);
      push_pred(!bad, 32'h1000 + i * 16);
      set_ex(32'h2000 + i * 4, 1'b1, 1'b1, 32'h1000 + i * 16);
      tick();
      set_ex('0, 1'b0, 1'b0, '0);
    end
    chk("perf_br_cnt", bus.br_cnt, 32'd10);
    chk("perf_mispred_cnt", bus.mispred_cnt, 32'd3);
    push_pred(1'b0, 32'h0);
    set_ex(32'h40, 1'b1, 1'b1, 32'h80);
    tick();
    set_ex('0, 1'b0, 1'b0, '0);
    #2;
    rst = 1'b1;
    #1;
    chk("perf_rst_br_cnt", bus.br_cnt, 32'h0);
    chk("perf_rst_mispred_cnt", bus.mispred_cnt, 32'h0);
    chk("perf_rst_wr_req", {31'b0, bus.wr_req}, 32'h0);
    tick();
    rst = 1'b0;
`endif

    // Randomized run against the reference model
    do_reset();
    m_dp = 0; m_dpc = 0; m_ep = 0; m_epc = 0; m_done = 0;
    m_wreq = 0; m_wpc = 0; m_wtgt = 0; m_wst = 0; m_br = 0; m_mis = 0;
    for (int n = 0; n < 1500; n++) begin
      logic        e_mis, e_wst, b, t, p_if;
      logic [31:0] e_red, e_wpc, e_wtgt, tgt, pce, pc_if;
      logic        bD, fD, bE, fE;

      chk("rnd_wr_req", {31'b0, bus.wr_req}, {31'b0, m_wreq});
      chk("rnd_wr_PC", bus.wr_PC, m_wpc);
      chk("rnd_wr_tgt", bus.wr_predicted_PC, m_wtgt);
      chk("rnd_wr_state", {31'b0, bus.wr_predicted_state_bit}, {31'b0, m_wst});
`ifdef BTB_PERF_EN
      chk("rnd_br_cnt", bus.br_cnt, m_br);
      chk("rnd_mispred_cnt", bus.mispred_cnt, m_mis);
`endif

      p_if  = 1'($urandom_range(0, 1));
      pc_if = 32'h100 * $urandom_range(1, 3);
      bD = ($urandom_range(0, 3) == 0);
      bE = ($urandom_range(0, 3) == 0);
      fD = ($urandom_range(0, 9) == 0);
      fE = ($urandom_range(0, 9) == 0);
      b  = 1'($urandom_range(0, 1));
      t  = 1'($urandom_range(0, 1));
      tgt = ($urandom_range(0, 1) == 1) ? m_epc : 32'h100 * $urandom_range(1, 3);
      pce = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      bus.rd_predicted = p_if; bus.rd_predicted_PC = pc_if;
      bus.bubbleD = bD; bus.flushD = fD; bus.bubbleE = bE; bus.flushE = fE;
      set_ex(pce, b, t, tgt);
      #2;

      // Expected resolution straight from the outcome table
      e_mis = 0; e_red = 0; e_wpc = 0; e_wtgt = 0; e_wst = 0;
      if (!m_done) begin
        if ((b && m_ep && t && tgt != m_epc) || (b && !m_ep && t)) begin
          e_mis = 1; e_red = tgt; e_wpc = pce; e_wtgt = tgt; e_wst = 1;
        end else if ((b && m_ep && !t) || (!b && m_ep)) begin
          e_mis = 1; e_red = pce + 32'd4; e_wpc = pce; e_wtgt = m_epc; e_wst = 0;
        end
      end
      chk("rnd_mispredict", {31'b0, bus.mispredict}, {31'b0, e_mis});
      if (e_mis) chk("rnd_redirect", bus.redirect_PC, e_red);

      if (!m_done && b && m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
      if (e_mis && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
      m_wreq = e_mis;
      if (e_mis) begin m_wpc = e_wpc; m_wtgt = e_wtgt; m_wst = e_wst; end
      // The EX occupant counts as handled once it resolves while stalled.
      if (fE || !bE) m_done = 0;
      else if (b || m_ep) m_done = 1;
      if (fE) begin m_ep = 0; m_epc = 0; end
      else if (!bE) begin m_ep = m_dp; m_epc = m_dpc; end
      if (fD) begin m_dp = 0; m_dpc = 0; end
      else if (!bD) begin m_dp = p_if; m_dpc = pc_if; end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
